// File: rtl/timing_control_sequencer.sv
// timing_control_sequencer
//   Timing and decode control unit for the RISC CPU. A binary T-state counter
//   drives a one-hot timing vector T. The opcode and condition fields of the
//   instruction bus are captured once per instruction, in state DEC_T. The
//   captured opcode produces the one-hot decode D.
//   Each opcode's final T-state comes from the packed END_T table. The table
//   holds one 4-bit entry per opcode, with opcode 0 in the LSBs.
//   Opcode BR_OPC jumps to BR_TGT when the selected flag is set in one of the
//   states BR_CHK_LO..BR_CHK_HI.
//   If the counter wraps past NUM_T-1 without reaching an end state, the
//   sticky seq_err flag is set.
// Ports
//   clk        in  1         rising-edge clock
//   R          in  1         asynchronous active-high reset
//   stall      in  1         hold all sequencing state this cycle
//   in_bus     in  BUS_W     instruction bus (opcode and cond fields used)
//   flags      in  FLAG_W    status flags (bit0 = carry)
//   T          out NUM_T     one-hot timing state
//   t_idx      out TW        binary index of the current T-state
//   D          out 2**OPC_W  one-hot latched opcode, zero until captured
//   instr_done out 1         pulse in the T0 cycle after an instruction ends
//   seq_err    out 1         sticky sequencing error
module timing_control_sequencer #(
  parameter int BUS_W     = 64,
  parameter int OPC_W     = 3,
  parameter int OPC_LSB   = 37,
  parameter int COND_LSB  = 34,
  parameter int FLAG_W    = 4,
  parameter int NUM_T     = 16,
  parameter int DEC_T     = 2,
  parameter logic [4*(2**OPC_W)-1:0] END_T = 32'hC6455555,
  parameter int BR_OPC    = 7,
  parameter int BR_CHK_LO = 6,
  parameter int BR_CHK_HI = 7,
  parameter int BR_TGT    = 11,
  localparam int TW = $clog2(NUM_T),
  localparam int CW = (FLAG_W > 1) ? $clog2(FLAG_W) : 1,
  localparam int DW = 2**OPC_W
) (
  input  logic             clk,
  input  logic             R,
  input  logic             stall,
  input  logic [BUS_W-1:0] in_bus,
  input  logic [FLAG_W-1:0] flags,
  output logic [NUM_T-1:0] T,
  output logic [TW-1:0]    t_idx,
  output logic [DW-1:0]    D,
  output logic             instr_done,
  output logic             seq_err
);

  // Parameter sanity checks at elaboration.
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_end_chk
      if (!((END_T[gi*4 +: 4] > DEC_T) && (END_T[gi*4 +: 4] < NUM_T))) begin : g_bad_end
        $error("END_T entry %0d out of range", gi);
      end
    end
    if (BR_TGT >= NUM_T) begin : g_bad_tgt
      $error("BR_TGT must be below NUM_T");
    end
    if (BR_CHK_LO <= DEC_T) begin : g_bad_lo
      $error("BR_CHK_LO must be after DEC_T");
    end
    if (BR_CHK_LO > BR_CHK_HI) begin : g_bad_range
      $error("BR_CHK_LO must not exceed BR_CHK_HI");
    end
  endgenerate

  logic [TW-1:0]    r_t_idx;
  logic [OPC_W-1:0] r_opc;
  logic [CW-1:0]    r_cond;
  logic             r_dec_valid;
  logic             r_instr_done;
  logic             r_seq_err;

  // The packed END_T parameter is unpacked into one entry per opcode.
  logic [3:0] w_end_tbl [DW];
  generate
    for (gi = 0; gi < DW; gi++) begin : g_end_tbl
      assign w_end_tbl[gi] = END_T[gi*4 +: 4];
    end
  endgenerate

  logic [3:0] w_end_nib;
  logic       w_capture;
  logic       w_at_end;
  logic       w_in_chk;
  logic       w_take_br;
  logic       w_last;
  logic       w_unused;

  assign w_end_nib = w_end_tbl[r_opc];
  assign w_capture = (r_t_idx == TW'(DEC_T));
  // dec_valid gates end and jump, so neither can fire before the fields are captured.
  assign w_at_end  = r_dec_valid && (r_t_idx == TW'(w_end_nib));
  assign w_in_chk  = (r_t_idx >= TW'(BR_CHK_LO)) && (r_t_idx <= TW'(BR_CHK_HI));
  assign w_take_br = r_dec_valid && (r_opc == OPC_W'(BR_OPC)) && w_in_chk && flags[r_cond];
  assign w_last    = (r_t_idx == TW'(NUM_T - 1));
  // Only the opcode and cond fields of the bus are meaningful here.
  assign w_unused  = ^in_bus;

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_t_idx      <= '0;
      r_opc        <= '0;
      r_cond       <= '0;
      r_dec_valid  <= 1'b0;
      r_instr_done <= 1'b0;
      r_seq_err    <= 1'b0;
    end else if (stall) begin
      r_instr_done <= 1'b0;
    end else begin
      r_instr_done <= 1'b0;
      if (w_at_end) begin
        r_t_idx      <= '0;
        r_dec_valid  <= 1'b0;
        r_instr_done <= 1'b1;
      end else if (w_take_br) begin
        r_t_idx <= TW'(BR_TGT);
      end else if (w_last) begin
        r_t_idx     <= '0;
        r_dec_valid <= 1'b0;
        r_seq_err   <= 1'b1;
      end else begin
        r_t_idx <= r_t_idx + 1'b1;
      end
      // An end state always lies after DEC_T, so this never collides with the clears above.
      if (w_capture) begin
        r_opc       <= in_bus[OPC_LSB +: OPC_W];
        r_cond      <= in_bus[COND_LSB +: CW];
        r_dec_valid <= 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_T; gi++) begin : g_t_dec
      assign T[gi] = (r_t_idx == TW'(gi));
    end
    for (gi = 0; gi < DW; gi++) begin : g_op_dec
      assign D[gi] = r_dec_valid && (r_opc == OPC_W'(gi));
    end
  endgenerate

  assign t_idx      = r_t_idx;
  assign instr_done = r_instr_done;
  assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_timing_control_sequencer.sv
module tb_timing_control_sequencer;

  logic        clk = 1'b0;
  logic        R = 1'b0;
  logic        stall = 1'b0;
  logic [63:0] in_bus = '0;
  logic [3:0]  flags = '0;

  logic [15:0] a_T, b_T;
  logic [3:0]  a_idx, b_idx;
  logic [7:0]  a_D, b_D;
  logic        a_done, b_done, a_err, b_err;

  always #5 clk = ~clk;

  timing_control_sequencer dut_a (
    .clk(clk), .R(R), .stall(stall), .in_bus(in_bus), .flags(flags),
    .T(a_T), .t_idx(a_idx), .D(a_D), .instr_done(a_done), .seq_err(a_err)
  );

  timing_control_sequencer #(.BR_TGT(13)) dut_b (
    .clk(clk), .R(R), .stall(stall), .in_bus(in_bus), .flags(flags),
    .T(b_T), .t_idx(b_idx), .D(b_D), .instr_done(b_done), .seq_err(b_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each instruction's length comes from a table of final states.
  // Index 0 models the default unit; index 1 models the one with jump target 13.
  int END_LEN [8] = '{5, 5, 5, 5, 5, 4, 6, 12};
  int TGT [2]     = '{11, 13};
  int m_t [2], m_opc [2], m_cond [2];
  bit m_valid [2], m_done [2], m_err [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_opc[i] = 0; m_cond[i] = 0;
      m_valid[i] = 0; m_done[i] = 0; m_err[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      int old_t;
      if (R) begin
        m_t[i] = 0; m_opc[i] = 0; m_cond[i] = 0;
        m_valid[i] = 0; m_done[i] = 0; m_err[i] = 0;
        continue;
      end
      m_done[i] = 0;
      if (stall) continue;
      old_t = m_t[i];
      if (m_valid[i] && old_t == END_LEN[m_opc[i]]) begin
        m_t[i] = 0; m_valid[i] = 0; m_done[i] = 1;
      end else if (m_valid[i] && m_opc[i] == 7 && old_t >= 6 && old_t <= 7 && flags[m_cond[i]]) begin
        m_t[i] = TGT[i];
      end else if (old_t == 15) begin
        m_t[i] = 0; m_valid[i] = 0; m_err[i] = 1;
      end else begin
        m_t[i] = old_t + 1;
      end
      if (old_t == 2) begin
        m_opc[i]   = int'(in_bus[39:37]);
        m_cond[i]  = int'(in_bus[35:34]);
        m_valid[i] = 1;
      end
    end
  endfunction

  task automatic compare_model();
    check("model_a_T",    32'(a_T),    32'(1) << m_t[0]);
    check("model_a_idx",  32'(a_idx),  32'(m_t[0]));
    check("model_a_D",    32'(a_D),    m_valid[0] ? (32'(1) << m_opc[0]) : 32'd0);
    check("model_a_done", 32'(a_done), 32'(m_done[0]));
    check("model_a_err",  32'(a_err),  32'(m_err[0]));
    check("model_b_T",    32'(b_T),    32'(1) << m_t[1]);
    check("model_b_idx",  32'(b_idx),  32'(m_t[1]));
    check("model_b_D",    32'(b_D),    m_valid[1] ? (32'(1) << m_opc[1]) : 32'd0);
    check("model_b_done", 32'(b_done), 32'(m_done[1]));
    check("model_b_err",  32'(b_err),  32'(m_err[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  // Unused bus bits get random filler so that only the decoded fields matter.
  task automatic set_inputs(input logic [2:0] opc, input logic [1:0] cond,
                            input logic stl, input logic [3:0] flg);
    in_bus = {$urandom(), $urandom()};
    in_bus[39:37] = opc;
    in_bus[35:34] = cond;
    stall = stl;
    flags = flg;
  endtask

  task automatic do_reset();
    R = 1'b1;
    model_reset();
    #1;
    check("rst_a_T",    32'(a_T),    32'h1);
    check("rst_a_idx",  32'(a_idx),  32'h0);
    check("rst_a_D",    32'(a_D),    32'h0);
    check("rst_a_done", 32'(a_done), 32'h0);
    check("rst_a_err",  32'(a_err),  32'h0);
    check("rst_b_T",    32'(b_T),    32'h1);
    check("rst_b_err",  32'(b_err),  32'h0);
    R = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  opc;
    logic [1:0]  cond;
    logic        stl;
    logic [3:0]  flg;
    logic [15:0] exp_t;
    logic [7:0]  exp_d;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [2:0] o, input logic [1:0] c, input logic s,
                              input logic [3:0] f, input logic [15:0] et,
                              input logic [7:0] ed, input logic edn);
    vec_t v;
    v.opc = o; v.cond = c; v.stl = s; v.flg = f;
    v.exp_t = et; v.exp_d = ed; v.exp_done = edn;
    vecs.push_back(v);
  endfunction

  initial begin
    // Opcode 0: a six-cycle walk T0..T5.
    add(3'd0, 2'd0, 1'b0, 4'h0, 16'h0002, 8'h00, 1'b0);
    add(3'd0, 2'd0, 1'b0, 4'h0, 16'h0004, 8'h00, 1'b0);
    add(3'd0, 2'd0, 1'b0, 4'h0, 16'h0008, 8'h01, 1'b0);
    add(3'd0, 2'd0, 1'b0, 4'h0, 16'h0010, 8'h01, 1'b0);
    add(3'd0, 2'd0, 1'b0, 4'h0, 16'h0020, 8'h01, 1'b0);
    add(3'd0, 2'd0, 1'b0, 4'h0, 16'h0001, 8'h00, 1'b1);
    // Opcode 7, carry set: jump from T6 to T11.
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h0002, 8'h00, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h0004, 8'h00, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h0008, 8'h80, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h0010, 8'h80, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h0020, 8'h80, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h0040, 8'h80, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h0800, 8'h80, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h1000, 8'h80, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h1, 16'h0001, 8'h00, 1'b1);
    // Opcode 7, carry clear: full walk to T12.
    for (int k = 1; k <= 12; k++)
      add(3'd7, 2'd0, 1'b0, 4'h0, 16'(32'(1) << k), (k >= 3) ? 8'h80 : 8'h00, 1'b0);
    add(3'd7, 2'd0, 1'b0, 4'h0, 16'h0001, 8'h00, 1'b1);
    // Opcode 1 with a three-cycle stall at T4.
    add(3'd1, 2'd0, 1'b0, 4'h0, 16'h0002, 8'h00, 1'b0);
    add(3'd1, 2'd0, 1'b0, 4'h0, 16'h0004, 8'h00, 1'b0);
    add(3'd1, 2'd0, 1'b0, 4'h0, 16'h0008, 8'h02, 1'b0);
    add(3'd1, 2'd0, 1'b0, 4'h0, 16'h0010, 8'h02, 1'b0);
    add(3'd1, 2'd0, 1'b1, 4'hF, 16'h0010, 8'h02, 1'b0);
    add(3'd1, 2'd0, 1'b1, 4'hF, 16'h0010, 8'h02, 1'b0);
    add(3'd1, 2'd0, 1'b1, 4'hF, 16'h0010, 8'h02, 1'b0);
    add(3'd1, 2'd0, 1'b0, 4'h0, 16'h0020, 8'h02, 1'b0);
    add(3'd1, 2'd0, 1'b0, 4'h0, 16'h0001, 8'h00, 1'b1);
    // Opcode 2, bus switches to opcode 6 after capture: decode must not follow.
    add(3'd2, 2'd0, 1'b0, 4'h0, 16'h0002, 8'h00, 1'b0);
    add(3'd2, 2'd0, 1'b0, 4'h0, 16'h0004, 8'h00, 1'b0);
    add(3'd2, 2'd0, 1'b0, 4'h0, 16'h0008, 8'h04, 1'b0);
    add(3'd6, 2'd0, 1'b0, 4'h0, 16'h0010, 8'h04, 1'b0);
    add(3'd6, 2'd0, 1'b0, 4'h0, 16'h0020, 8'h04, 1'b0);
    add(3'd6, 2'd0, 1'b0, 4'h0, 16'h0001, 8'h00, 1'b1);

    set_inputs(3'd0, 2'd0, 1'b0, 4'h0);
    #1;
    do_reset();

    for (int k = 0; k < vecs.size(); k++) begin
      set_inputs(vecs[k].opc, vecs[k].cond, vecs[k].stl, vecs[k].flg);
      tick();
      check($sformatf("vec%0d_T", k),    32'(a_T),    32'(vecs[k].exp_t));
      check($sformatf("vec%0d_D", k),    32'(a_D),    32'(vecs[k].exp_d));
      check($sformatf("vec%0d_done", k), 32'(a_done), 32'(vecs[k].exp_done));
      check($sformatf("vec%0d_err", k),  32'(a_err),  32'h0);
    end

    // Jump target beyond the instruction end: wraps and flags a sequencing error.
    do_reset();
    set_inputs(3'd7, 2'd0, 1'b0, 4'h1);
    repeat (7) tick();
    check("tgt13_T13", 32'(b_T), 32'h2000);
    tick();
    check("tgt13_T14", 32'(b_T), 32'h4000);
    tick();
    check("tgt13_T15", 32'(b_T), 32'h8000);
    tick();
    check("tgt13_wrap_T",    32'(b_T),    32'h0001);
    check("tgt13_wrap_err",  32'(b_err),  32'h1);
    check("tgt13_wrap_done", 32'(b_done), 32'h0);
    set_inputs(3'd0, 2'd0, 1'b0, 4'h0);
    repeat (6) tick();
    check("tgt13_next_done", 32'(b_done), 32'h1);
    check("tgt13_next_err",  32'(b_err),  32'h1);

    // Asynchronous reset in the middle of T8 of opcode 7.
    do_reset();
    set_inputs(3'd7, 2'd0, 1'b0, 4'h0);
    repeat (8) tick();
    check("mid_pre_T", 32'(a_T), 32'h0100);
    #4;
    R = 1'b1;
    model_reset();
    #1;
    check("mid_rst_a_T", 32'(a_T), 32'h0001);
    check("mid_rst_a_D", 32'(a_D), 32'h00);
    check("mid_rst_b_T", 32'(b_T), 32'h0001);
    check("mid_rst_b_D", 32'(b_D), 32'h00);
    R = 1'b0;
    set_inputs(3'd0, 2'd0, 1'b0, 4'h0);
    repeat (6) tick();
    check("mid_after_done", 32'(a_done), 32'h1);
    check("mid_after_T",    32'(a_T),    32'h0001);

    // Randomised run against the model, including stalls and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      R = ($urandom_range(0, 199) == 0);
      set_inputs(($urandom_range(0, 1) == 1) ? 3'd7 : 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0),
                 4'($urandom_range(0, 15)));
      tick();
    end
    R = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
